// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, single-outstanding imem handshake, skid buffer and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000,
  parameter logic [ADDRESS_WIDTH-1:0] NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_valid,
  input  logic [ADDRESS_WIDTH-1:0] imem_rdata,
  input  logic                     StallF,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic [ADDRESS_WIDTH-1:0] InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic [31:0]              FetchCount,
  output logic [31:0]              BubbleCount
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] skid_q, skid_d;
  logic [ADDRESS_WIDTH-1:0] instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pcd_q, pcd_d;
  logic [ADDRESS_WIDTH-1:0] pcp4_q, pcp4_d;
  logic                     valid_q, valid_d;

  logic                     load_s;
  logic [ADDRESS_WIDTH-1:0] load_instr_s;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_s;
  logic [ADDRESS_WIDTH-1:0] target_s;
  logic                     unused_s;

  assign pc_plus4_s = pc_q + {{(ADDRESS_WIDTH-3){1'b0}}, 3'd4};
  assign target_s   = {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_s   = ^PCTargetE[1:0];

  // State, PC, skid and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // Next state, PC and skid; redirect always wins over stall
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    load_s       = 1'b0;
    load_instr_s = skid_q;
    case (state_q)
      S_FETCH: begin
        if (PCSrcE) begin
          pc_d = target_s;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          pc_d    = target_s;
          state_d = imem_valid ? S_FETCH : S_DROP;
        end else if (imem_valid) begin
          if (StallF) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            load_s       = 1'b1;
            load_instr_s = imem_rdata;
            pc_d         = pc_plus4_s;
            state_d      = S_FETCH;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_d    = target_s;
          skid_d  = '0;
          state_d = S_FETCH;
        end else if (!StallF) begin
          load_s  = 1'b1;
          pc_d    = pc_plus4_s;
          skid_d  = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (PCSrcE) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_valid) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // IF/ID: flush beats load; without a load or stall decode gets a bubble
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_s) begin
      instr_d = load_instr_s;
      pcd_d   = pc_q;
      pcp4_d  = pc_plus4_s;
      valid_d = 1'b1;
    end else if (StallF) begin
      valid_d = valid_q;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // Memory request strobe, only ever raised in FETCH
  always_comb begin
    if (rst && (state_q == S_FETCH) && !PCSrcE) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counter increments
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + ((load_s && !FlushD) ? 32'd1 : 32'd0);
    bubble_cnt_d = bubble_cnt_q + (valid_q ? 32'd0 : 32'd1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`else
  assign FetchCount  = 32'd0;
  assign BubbleCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency memory responder.
module tb_fetch_stage;

  localparam logic [31:0] OFS = 32'h1000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        StallF, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [31:0] FetchCount, BubbleCount;

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 1;
  int          cyc      = 0;
  logic        pend     = 1'b0;
  int          cnt      = 0;
  logic [31:0] pend_addr = 32'd0;
  logic        req_seen;
  logic [31:0] addr_seen;
  logic [31:0] dq[$];
  logic [31:0] rq[$];
  int          rt[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .StallF(StallF),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchCount(FetchCount), .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: present memory response, sample request, advance the edge, log decode
  task automatic tick();
    if (pend && cnt == 1) begin
      imem_valid = 1'b1;
      imem_rdata = pend_addr + OFS;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    #1;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    if (rst) check("one_outstanding", {31'd0, imem_req && pend && !imem_valid}, 32'd0);
    if (imem_valid) pend = 1'b0;
    else if (pend) cnt--;
    if (imem_req) begin
      pend = 1'b1; cnt = lat; pend_addr = imem_addr;
      rq.push_back(imem_addr); rt.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ValidD) begin
      dq.push_back(PCD);
      check("instr_match", InstrD, PCD + OFS);
      check("pcplus4", PCPlus4D, PCD + 32'd4);
    end
  endtask

  task automatic clear_logs();
    dq.delete(); rq.delete(); rt.delete();
  endtask

  initial begin
    rst = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
    StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    @(posedge clk); #1;
    tick(); tick();
    check("rst_valid", {31'd0, ValidD}, 32'd0);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 32'd0);
    check("rst_pcp4", PCPlus4D, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_fcnt", FetchCount, 32'd0);
    check("rst_bcnt", BubbleCount, 32'd0);

    // 1-cycle memory: one instruction every two cycles
    rst = 1'b1; clear_logs();
    for (int i = 0; i < 6; i++) tick();
    check("t1_ndec", dq.size(), 32'd3);
    check("t1_nreq", rq.size(), 32'd3);
    for (int i = 0; i < 3 && i < dq.size(); i++) check("t1_pcd", dq[i], 32'(i * 4));
    for (int i = 0; i < 3 && i < rq.size(); i++) check("t1_addr", rq[i], 32'(i * 4));
    for (int i = 1; i < rt.size(); i++) check("t1_req_gap", 32'(rt[i] - rt[i-1]), 32'd2);

    // 3-cycle memory: request every four cycles
    lat = 3; clear_logs();
    for (int i = 0; i < 8; i++) tick();
    check("t2_ndec", dq.size(), 32'd2);
    check("t2_nreq", rq.size(), 32'd2);
    if (dq.size() == 2) begin
      check("t2_pcd0", dq[0], 32'h0C);
      check("t2_pcd1", dq[1], 32'h10);
    end
    if (rt.size() == 2) check("t2_req_gap", 32'(rt[1] - rt[0]), 32'd4);

    // Stall arriving with the WAIT response
    lat = 1; clear_logs();
    tick();
    check("t3_req20", addr_seen, 32'h14);
    StallF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_noreq", {31'd0, req_seen}, 32'd0);
      check("t3_valid_frozen", {31'd0, ValidD}, 32'd0);
      check("t3_pcd_frozen", PCD, 32'h10);
    end
    StallF = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t3_ndec", dq.size(), 32'd2);
    if (dq.size() == 2) begin
      check("t3_pcd0", dq[0], 32'h14);
      check("t3_pcd1", dq[1], 32'h18);
    end

    // Redirect while a response is still outstanding
    lat = 2; clear_logs();
    tick();
    check("t4_req28", addr_seen, 32'h1C);
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    tick();
    PCSrcE = 1'b0; PCTargetE = 32'd0;
    check("t4_drop_valid", {31'd0, ValidD}, 32'd0);
    tick();
    check("t4_stale_ignored", {31'd0, ValidD}, 32'd0);
    lat = 1; clear_logs();
    for (int i = 0; i < 4; i++) tick();
    check("t4_nreq", rq.size(), 32'd2);
    if (rq.size() > 0) check("t4_first_addr", rq[0], 32'h100);
    check("t4_ndec", dq.size(), 32'd2);
    if (dq.size() == 2) begin
      check("t4_pcd0", dq[0], 32'h100);
      check("t4_pcd1", dq[1], 32'h104);
    end

    // Redirect + flush + stall together
    check("t5_pre_valid", {31'd0, ValidD}, 32'd1);
    PCSrcE = 1'b1; PCTargetE = 32'h200; FlushD = 1'b1; StallF = 1'b1;
    tick();
    PCSrcE = 1'b0; PCTargetE = 32'd0; FlushD = 1'b0; StallF = 1'b0;
    check("t5_noreq", {31'd0, req_seen}, 32'd0);
    check("t5_valid", {31'd0, ValidD}, 32'd0);
    check("t5_instr", InstrD, NOP);
    tick();
    check("t5_req", {31'd0, req_seen}, 32'd1);
    check("t5_addr", addr_seen, 32'h200);

    // Reset in the middle of WAIT
    rst = 1'b0;
    tick();
    check("t6_valid", {31'd0, ValidD}, 32'd0);
    check("t6_req", {31'd0, imem_req}, 32'd0);
    check("t6_fcnt", FetchCount, 32'd0);
    check("t6_bcnt", BubbleCount, 32'd0);
    rst = 1'b1;
    tick();
    check("t6_req_after", {31'd0, req_seen}, 32'd1);
    check("t6_addr_after", addr_seen, 32'd0);
    tick();
    check("t6_pcd", PCD, 32'd0);
    check("t6_vd", {31'd0, ValidD}, 32'd1);

    // PC+4 wraps at the top of the address space
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    tick();
    PCSrcE = 1'b0; PCTargetE = 32'd0;
    tick();
    check("t7_addr", addr_seen, 32'hFFFF_FFFC);
    tick();
    check("t7_pcd", PCD, 32'hFFFF_FFFC);
    check("t7_pcp4_wrap", PCPlus4D, 32'd0);
    tick();
    check("t7_next_addr", addr_seen, 32'd0);

`ifndef FETCH_PERF_CNT_EN
    check("cnt_tied_f", FetchCount, 32'd0);
    check("cnt_tied_b", BubbleCount, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
